// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - instruction field positions, opcode classes and state type for the MCU sequencer
package mcu_pkg;

   // Instruction field positions (16-bit encoding, low bits of the bus)
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 6;
   localparam int RS_LSB  = 3;
   localparam int IDX_W   = 3;
   localparam int IMM_W   = 6;

   // Opcode classes in ir[15:12]; anything else is illegal
   localparam logic [3:0] OPC_MOV   = 4'h0;
   localparam logic [3:0] OPC_MOVI  = 4'h1;
   localparam logic [3:0] OPC_LOAD  = 4'h2;
   localparam logic [3:0] OPC_STORE = 4'h3;
   localparam logic [3:0] OPC_ALU   = 4'h4;
   localparam logic [3:0] OPC_ALUI  = 4'h5;
   localparam logic [3:0] OPC_HALT  = 4'hF;

   typedef enum logic [4:0] {
      S_FETCH_ADDR,
      S_FETCH_WAIT,
      S_FETCH_IR,
      S_DECODE,
      S_MOV_EX,
      S_MOVI_EX,
      S_A0,
      S_A1,
      S_A2,
      S_A3,
      S_L0,
      S_L1,
      S_L2,
      S_S0,
      S_S1,
      S_S2,
      S_RETIRE,
      S_HALT,
      S_FAULT
   } state_t;

   // Classes whose src field names a register and therefore must be in range;
   // MOVI/ALUI reuse those bits as immediate data.
   function automatic logic uses_src(input logic [3:0] opc);
      return (opc == OPC_MOV) || (opc == OPC_LOAD) ||
             (opc == OPC_STORE) || (opc == OPC_ALU);
   endfunction

endpackage

// File: rtl/mcu_onehot_dec.sv
// rtl/mcu_onehot_dec.sv - register index to one-hot enable decoder with range flag
// Ports:
//   idx    in  IDX_W  register index
//   en     in  1      gates the one-hot output
//   onehot out N      one-hot enable (all zero when en=0 or idx out of range)
//   valid  out 1      idx < N, independent of en
module mcu_onehot_dec
   import mcu_pkg::*;
#(
   parameter int N = 6
) (
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N-1:0]     onehot,
   output logic             valid
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         onehot[i] = en && (idx == IDX_W'(i));
      end
   end

   assign valid = (int'(idx) < N);

endmodule

// File: rtl/mcu_sequencer.sv
// rtl/mcu_sequencer.sv - unified fetch/decode/execute control sequencer for the bus-based MCU
// Optional feature: define MFC_TIMEOUT_EN to fault when mfc does not arrive
// within MFC_TIMEOUT wait cycles; without it memory waits are unbounded.
// Ports:
//   clk, rst (async, active low)
//   ir            instruction register contents; mfc memory function complete
//   pc_out/pc_inc PC bus drive / increment     ir_en IR load
//   mar_en        MAR load                     mem_en/mem_rw memory request, 1=read
//   mdr_rd_en/mdr_wr_en/mdr_out  MDR controls
//   alu_in0/alu_in1/alu_latch/alu_out_en       ALU controls
//   imm_out/imm_value  sign-extended ir[5:0] and its bus drive
//   reg_in/reg_out one-hot register load / bus drive
//   instr_done retire pulse; halted, fault sticky status
module mcu_sequencer
   import mcu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int NUM_REGS    = 6,
   parameter int MFC_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   ir,
   input  logic                mfc,
   output logic                pc_out,
   output logic                pc_inc,
   output logic                ir_en,
   output logic                mar_en,
   output logic                mem_en,
   output logic                mem_rw,
   output logic                mdr_rd_en,
   output logic                mdr_wr_en,
   output logic                mdr_out,
   output logic                alu_in0,
   output logic                alu_in1,
   output logic                alu_latch,
   output logic                alu_out_en,
   output logic                imm_out,
   output logic [DATA_W-1:0]   imm_value,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic                instr_done,
   output logic                halted,
   output logic                fault
);

   state_t           state, state_nxt;
   logic [3:0]       opc;
   logic [IDX_W-1:0] rd, rs, out_idx;
   logic             in_en, out_en;
   logic             rd_ok, rs_ok;
   logic             wait_st;
   logic             timeout_hit;
   logic             unused_cfg;

   assign opc       = ir[OPC_MSB:OPC_LSB];
   assign rd        = ir[RD_LSB +: IDX_W];
   assign rs        = ir[RS_LSB +: IDX_W];
   assign imm_value = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
   assign wait_st   = (state == S_FETCH_WAIT) || (state == S_L1) || (state == S_S2);

   // reg_in always targets rd; reg_out selects rs or rd depending on the step.
   // In DECODE out_idx rests on rs, so the two valid flags are the range checks.
   mcu_onehot_dec #(.N(NUM_REGS)) u_dec_in (
      .idx    (rd),
      .en     (in_en),
      .onehot (reg_in),
      .valid  (rd_ok)
   );

   mcu_onehot_dec #(.N(NUM_REGS)) u_dec_out (
      .idx    (out_idx),
      .en     (out_en),
      .onehot (reg_out),
      .valid  (rs_ok)
   );

`ifdef MFC_TIMEOUT_EN
   localparam int TO_W = $clog2(MFC_TIMEOUT + 1);
   logic [TO_W-1:0] wait_cnt;

   // Wait states are never back to back, so clearing outside them clears on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          wait_cnt <= '0;
      else if (!wait_st) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + TO_W'(1);
   end

   assign timeout_hit = wait_st && (wait_cnt == TO_W'(MFC_TIMEOUT - 1));
   assign unused_cfg  = ^ir[11:9];
`else
   assign timeout_hit = 1'b0;
   // The ALU op field goes straight to the ALU; MFC_TIMEOUT only matters with the timeout.
   assign unused_cfg  = ^{ir[11:9], 32'(MFC_TIMEOUT)};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH_ADDR;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH_ADDR: state_nxt = S_FETCH_WAIT;
         S_FETCH_WAIT: if (mfc) state_nxt = S_FETCH_IR;
                       else if (timeout_hit) state_nxt = S_FAULT;
         S_FETCH_IR:   state_nxt = S_DECODE;
         S_DECODE: begin
            if (opc == OPC_HALT)                              state_nxt = S_HALT;
            else if (!rd_ok || (uses_src(opc) && !rs_ok))     state_nxt = S_FAULT;
            else begin
               case (opc)
                  OPC_MOV:           state_nxt = S_MOV_EX;
                  OPC_MOVI:          state_nxt = S_MOVI_EX;
                  OPC_LOAD:          state_nxt = S_L0;
                  OPC_STORE:         state_nxt = S_S0;
                  OPC_ALU, OPC_ALUI: state_nxt = S_A0;
                  default:           state_nxt = S_FAULT;
               endcase
            end
         end
         S_MOV_EX, S_MOVI_EX: state_nxt = S_RETIRE;
         S_A0:   state_nxt = S_A1;
         S_A1:   state_nxt = S_A2;
         S_A2:   state_nxt = S_A3;
         S_A3:   state_nxt = S_RETIRE;
         S_L0:   state_nxt = S_L1;
         S_L1:   if (mfc) state_nxt = S_L2;
                 else if (timeout_hit) state_nxt = S_FAULT;
         S_L2:   state_nxt = S_RETIRE;
         S_S0:   state_nxt = S_S1;
         S_S1:   state_nxt = S_S2;
         S_S2:   if (mfc) state_nxt = S_RETIRE;
                 else if (timeout_hit) state_nxt = S_FAULT;
         S_RETIRE: state_nxt = S_FETCH_ADDR;
         default:  state_nxt = state;   // HALT and FAULT hold until reset
      endcase
   end

   // Outputs are decoded from state; holding rst low forces the idle pattern
   // immediately, which also drops any in-flight memory request.
   always_comb begin
      pc_out     = 1'b0;
      pc_inc     = 1'b0;
      ir_en      = 1'b0;
      mar_en     = 1'b0;
      mem_en     = 1'b0;
      mem_rw     = 1'b1;
      mdr_rd_en  = 1'b0;
      mdr_wr_en  = 1'b0;
      mdr_out    = 1'b0;
      alu_in0    = 1'b0;
      alu_in1    = 1'b0;
      alu_latch  = 1'b0;
      alu_out_en = 1'b0;
      imm_out    = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
      in_en      = 1'b0;
      out_en     = 1'b0;
      out_idx    = rs;
      if (rst) begin
         case (state)
            S_FETCH_ADDR: begin pc_out = 1'b1; mar_en = 1'b1; end
            S_FETCH_WAIT: begin mem_en = 1'b1; mdr_rd_en = mfc; end
            S_FETCH_IR:   begin mdr_out = 1'b1; ir_en = 1'b1; end
            S_MOV_EX:     begin out_en = 1'b1; in_en = 1'b1; end
            S_MOVI_EX:    begin imm_out = 1'b1; in_en = 1'b1; end
            S_A0:         begin out_en = 1'b1; out_idx = rd; alu_in0 = 1'b1; end
            S_A1: begin
               alu_in1 = 1'b1;
               if (opc == OPC_ALUI) imm_out = 1'b1;
               else                 out_en  = 1'b1;
            end
            S_A2:         alu_latch = 1'b1;
            S_A3:         begin alu_out_en = 1'b1; in_en = 1'b1; end
            S_L0, S_S0:   begin out_en = 1'b1; mar_en = 1'b1; end
            S_L1:         begin mem_en = 1'b1; mdr_rd_en = mfc; end
            S_L2:         begin mdr_out = 1'b1; in_en = 1'b1; end
            S_S1:         begin out_en = 1'b1; out_idx = rd; mdr_wr_en = 1'b1; end
            S_S2:         begin mem_en = 1'b1; mem_rw = 1'b0; end
            S_RETIRE:     begin pc_inc = 1'b1; instr_done = 1'b1; end
            S_HALT:       halted = 1'b1;
            S_FAULT:      fault = 1'b1;
            default:      ;
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb/tb_mcu_sequencer.sv - scoreboard bench for mcu_sequencer with a modelled IR and memory
module tb_mcu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] ir  = '0;
   logic        mfc = 1'b0;
   logic        pc_out, pc_inc, ir_en, mar_en, mem_en, mem_rw;
   logic        mdr_rd_en, mdr_wr_en, mdr_out;
   logic        alu_in0, alu_in1, alu_latch, alu_out_en, imm_out;
   logic [15:0] imm_value;
   logic [5:0]  reg_in, reg_out;
   logic        instr_done, halted, fault;

   mcu_sequencer #(.DATA_W(16), .NUM_REGS(6), .MFC_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .ir(ir), .mfc(mfc),
      .pc_out(pc_out), .pc_inc(pc_inc), .ir_en(ir_en), .mar_en(mar_en),
      .mem_en(mem_en), .mem_rw(mem_rw), .mdr_rd_en(mdr_rd_en),
      .mdr_wr_en(mdr_wr_en), .mdr_out(mdr_out), .alu_in0(alu_in0),
      .alu_in1(alu_in1), .alu_latch(alu_latch), .alu_out_en(alu_out_en),
      .imm_out(imm_out), .imm_value(imm_value), .reg_in(reg_in),
      .reg_out(reg_out), .instr_done(instr_done), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;     // 0 retire, 1 halt, 2 fault
      int cyc;
      int rin;
      int rout;
      int pcinc;
      int mem;
      int memwr;
      int in_cyc;
      int imm;
      int bits;     // strobes active on the event cycle
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] instr = '0;
   int          wr_delay = 0;
   bit          mfc_never = 1'b0;
   int          evt_count = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // IR flop and memory: fetch/read answer on the first wait cycle,
   // writes after wr_delay extra cycles.
   int wcnt = 0;
   always @(negedge clk) begin
      if (!rst) begin
         mfc  = 1'b0;
         wcnt = 0;
      end else begin
         if (ir_en) ir = instr;
         if (mem_en) begin
            mfc  = !mfc_never && (wcnt == (mem_rw ? 0 : wr_delay));
            wcnt = wcnt + 1;
         end else begin
            mfc  = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Monitor: accumulates per-instruction activity, pops on retire/halt/fault.
   int          m_cyc, m_pcinc, m_mem, m_memwr, m_in_cyc, m_multi;
   int          m_rin, m_rout, m_imm, m_kind, m_bits, m_drv;
   bit          m_stop;
   exp_t        m_e;

   task automatic m_clear();
      m_cyc = 0; m_pcinc = 0; m_mem = 0; m_memwr = 0; m_in_cyc = 0;
      m_multi = 0; m_rin = 0; m_rout = 0; m_imm = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         m_clear();
         m_stop = 1'b0;
      end else if (!m_stop) begin
         m_cyc++;
         m_drv = $countones({pc_out, mdr_out, alu_out_en, imm_out, reg_out});
         if (m_drv > 1) m_multi++;
         m_rin  = m_rin | int'(reg_in);
         m_rout = m_rout | int'(reg_out);
         if (pc_inc) m_pcinc++;
         if (mem_en) m_mem++;
         if (mem_en && !mem_rw) m_memwr++;
         if (reg_in != '0 && m_in_cyc == 0) m_in_cyc = m_cyc;
         if (imm_out) m_imm = int'(imm_value);
         if (instr_done || halted || fault) begin
            m_kind = fault ? 2 : (halted ? 1 : 0);
            m_bits = $countones({pc_out, pc_inc, ir_en, mar_en, mem_en, mdr_rd_en,
                                 mdr_wr_en, mdr_out, alu_in0, alu_in1, alu_latch,
                                 alu_out_en, imm_out, |reg_in, |reg_out});
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event actual=%0d required=none", m_kind);
            end else begin
               m_e = exp_q.pop_front();
               chk("ev_kind",   m_kind,   m_e.kind);
               chk("ev_cycles", m_cyc,    m_e.cyc);
               chk("ev_reg_in", m_rin,    m_e.rin);
               chk("ev_reg_out",m_rout,   m_e.rout);
               chk("ev_pc_inc", m_pcinc,  m_e.pcinc);
               chk("ev_mem_en", m_mem,    m_e.mem);
               chk("ev_mem_wr", m_memwr,  m_e.memwr);
               chk("ev_in_cyc", m_in_cyc, m_e.in_cyc);
               chk("ev_imm",    m_imm,    m_e.imm);
               chk("ev_bits",   m_bits,   m_e.bits);
               chk("ev_one_driver", m_multi, 0);
            end
            if (m_kind != 0) m_stop = 1'b1;
            m_clear();
            evt_count++;
         end
      end
   end

   task automatic wait_evt(input int target);
      bit got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (evt_count >= target) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL evt_timeout actual=%0d required=%0d", evt_count, target);
      end
   endtask

   task automatic run_instr(input logic [15:0] w, input int dly, input int kind,
                            input int cyc, input int rin, input int rout,
                            input int pcinc, input int mem, input int memwr,
                            input int in_cyc, input int imm, input int bits);
      exp_t e;
      e.kind = kind; e.cyc = cyc; e.rin = rin; e.rout = rout; e.pcinc = pcinc;
      e.mem = mem; e.memwr = memwr; e.in_cyc = in_cyc; e.imm = imm; e.bits = bits;
      exp_q.push_back(e);
      instr    = w;
      wr_delay = dly;
      wait_evt(evt_count + 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_strobes", $countones({pc_out, pc_inc, ir_en, mar_en, mem_en, mdr_rd_en,
                                     mdr_wr_en, mdr_out, alu_in0, alu_in1, alu_latch,
                                     alu_out_en, imm_out, reg_in, reg_out, instr_done,
                                     halted, fault}), 0);
      chk("rst_mem_rw", int'(mem_rw), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rel_fetch_addr", int'({pc_out, mar_en}), 3);
      chk("rel_fault", int'(fault), 0);
   endtask

   int pc_cnt;
   bit seen;

   initial begin
      do_reset();
      //          ir       dly kind cyc rin   rout  pci mem mwr inc imm     bits
      run_instr(16'h0040, 0,  0,   6,  'h02, 'h01, 1,  1,  0,  5,  0,      1);  // MOV r1<-r0
      run_instr(16'h10BF, 0,  0,   6,  'h04, 'h00, 1,  1,  0,  5,  'hFFFF, 1);  // MOVI r2,-1
      run_instr(16'h40C8, 0,  0,   9,  'h08, 'h0A, 1,  1,  0,  8,  0,      1);  // ALU r3,r1
      run_instr(16'h5085, 0,  0,   9,  'h04, 'h04, 1,  1,  0,  8,  5,      1);  // ALUI r2,#5
      run_instr(16'h2142, 0,  0,   8,  'h20, 'h01, 1,  2,  0,  7,  0,      1);  // LOAD r5,[r0]
      run_instr(16'h3098, 4,  0,   12, 'h00, 'h0C, 1,  6,  5,  0,  0,      1);  // STORE [r3],r2
      run_instr(16'h01C0, 0,  2,   5,  'h00, 'h00, 0,  1,  0,  0,  0,      0);  // rd=7
      do_reset();
      run_instr(16'h0030, 0,  2,   5,  'h00, 'h00, 0,  1,  0,  0,  0,      0);  // rs=6
      do_reset();
      run_instr(16'h6000, 0,  2,   5,  'h00, 'h00, 0,  1,  0,  0,  0,      0);  // bad class
      do_reset();

      // Reset in the middle of a store wait drops the request at once.
      instr    = 16'h3098;
      wr_delay = 50;
      seen     = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (mem_en && !mem_rw) seen = 1'b1;
      end
      chk("abort_reached_write", int'(seen), 1);
      rst = 1'b0;
      #1;
      chk("abort_mem_en", int'(mem_en), 0);
      chk("abort_mem_rw", int'(mem_rw), 1);
      wr_delay = 0;
      instr    = 16'hF000;
      @(posedge clk);
      #1 rst = 1'b1;

`ifdef MFC_TIMEOUT_EN
      @(negedge clk);
      mfc_never = 1'b1;
      run_instr(16'h0040, 0,  2,   17, 'h00, 'h00, 0,  15, 0,  0,  0,      0);  // timeout
      mfc_never = 1'b0;
      do_reset();
`endif

      run_instr(16'hF000, 0,  1,   5,  'h00, 'h00, 0,  1,  0,  0,  0,      0);  // HALT
      pc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (pc_out || pc_inc) pc_cnt++;
      end
      chk("halt_no_pc", pc_cnt, 0);
      chk("halt_sticky", int'(halted), 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
